simon_dec_ctrl: RTL

SIMON_DEC_CTRL -- requirements
Module: simon_dec_ctrl

---
 rtl/simon_dec_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/simon_dec_ctrl.sv
// Iterative Simon block decryptor: a round-key store, an IDLE/RUN/DONE
// sequencer and one inverse-round datapath reused once per clock.

module round_inv #(
  parameter int n = 16,
  parameter int m = 4
) (
  input  logic [2*n-1:0] y,
  input  logic [n-1:0]   k,
  output logic [2*n-1:0] x
);

  if (m < 2 || m > 4) begin : g_bad_m
    $error("round_inv: key-word count m must be 2..4");
  end

  function automatic logic [n-1:0] rol(input logic [n-1:0] a, input int s);
    return (a << s) | (a >> (n - s));
  endfunction

  logic [n-1:0] y_l;
  logic [n-1:0] y_r;

  assign y_l = y[2*n-1:n];
  assign y_r = y[n-1:0];

  // Undo one forward round: the old left word is the current right word.
  assign x = {y_r, y_l ^ (rol(y_r, 1) & rol(y_r, 8)) ^ rol(y_r, 2) ^ k};

endmodule

module simon_dec_ctrl #(
  parameter int N      = 16,
  parameter int ROUNDS = 32
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           key_we,
  input  logic [4:0]     key_addr,
  input  logic [N-1:0]   key_data,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_data,
  output logic           busy
);

  localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [5:0] ROUNDS_W = 6'(ROUNDS);

  logic [1:0]     fsm_q, fsm_d;
  logic [2*N-1:0] state_q, state_d;
  logic [2*N-1:0] round_out;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   key_q [ROUNDS];
  logic [N-1:0]   key_d [ROUNDS];
  logic           key_wr_en;

  assign key_wr_en = key_we && (fsm_q == IDLE) && ({1'b0, key_addr} < ROUNDS_W);

  always_comb begin
    key_d = key_q;
    if (key_wr_en) begin
      key_d[key_addr[CW-1:0]] = key_data;
    end
  end

  // Keys survive reset so a block can be restarted without reloading them.
  always_ff @(posedge clk) begin
    key_q <= key_d;
  end

  round_inv #(
    .n(N),
    .m(4)
  ) u_round (
    .y(state_q),
    .k(key_q[cnt_q]),
    .x(round_out)
  );

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = in_data;
          cnt_d   = CW'(ROUNDS - 1);
          fsm_d   = RUN;
        end
      end
      RUN: begin
        state_d = round_out;
        if (cnt_q == '0) begin
          fsm_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake flags come straight from the state so reset clears them at once.
  assign in_ready  = (fsm_q == IDLE);
  assign busy      = (fsm_q == RUN);
  assign out_valid = (fsm_q == DONE);
  assign out_data  = state_q;

endmodule
